muldiv_unit: RTL and testbench

Iterative multiply/divide unit implementing the eight RV32M operations on a parameterisable datapath width. It sits beside `alu` in the execute stage and takes over the M-extension opcodes. The core stalls on `busy` and captures `out` when `done` pulses. Latency is fixed and data-independent: one result bit per cycle, plus a sign-fixup cycle.

---
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      op;
    logic [XLEN-1:0] in_1;
    logic [XLEN-1:0] in_2;
    logic [XLEN-1:0] out;
    logic            busy;
    logic            done;

    modport master (
        output start, kill, op, in_1, in_2,
        input  out, busy, done
    );

    modport slave (
        input  start, kill, op, in_1, in_2,
        output out, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one result bit per cycle followed by a
// sign-fixup cycle, so latency is fixed at XLEN+2 cycles for every operation.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [CW-1:0]     r_count;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_out;

    logic [1:0]        w_next;
    logic              w_accept;
    logic              w_sgn_a;
    logic              w_sgn_b;
    logic              w_b_zero;
    logic              w_neg;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN+1:0]   w_div_trial;
    logic              w_div_ge;
    logic [XLEN:0]     w_div_rem_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_remv;
    logic [XLEN-1:0]   w_result;

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
    assign w_b_zero = (bus.in_2 == {XLEN{1'b0}});

    // Next-state logic; kill overrides everything while an operation is in flight.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE, S_DONE: w_next = bus.start ? S_CALC : S_IDLE;
            S_CALC:         w_next = bus.kill ? S_IDLE :
                                     ((r_count == CNT_LAST) ? S_FIX : S_CALC);
            S_FIX:          w_next = bus.kill ? S_IDLE : S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    // Operand signs, magnitudes and the result sign recorded at start.
    always_comb begin
        w_sgn_a = 1'b0;
        w_sgn_b = 1'b0;
        case (bus.op)
            3'd1, 3'd4, 3'd6: begin
                w_sgn_a = bus.in_1[XLEN-1];
                w_sgn_b = bus.in_2[XLEN-1];
            end
            3'd2:    w_sgn_a = bus.in_1[XLEN-1];
            default: w_sgn_a = 1'b0;
        endcase
        w_mag_a = w_sgn_a ? -bus.in_1 : bus.in_1;
        w_mag_b = w_sgn_b ? -bus.in_2 : bus.in_2;
        case (bus.op)
            3'd4, 3'd5: w_neg = (w_sgn_a ^ w_sgn_b) & ~w_b_zero;
            3'd6, 3'd7: w_neg = w_sgn_a;
            default:    w_neg = w_sgn_a ^ w_sgn_b;
        endcase
    end

    // One shift-add (multiply) or restoring-subtract (divide) step.
    // A zero divisor naturally yields an all-ones quotient and the dividend as remainder.
    always_comb begin
        w_mul_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
        w_div_trial    = {r_rem, r_acc[XLEN-1]} - {2'b00, r_b};
        w_div_ge       = ~w_div_trial[XLEN+1];
        w_div_rem_next = w_div_ge ? w_div_trial[XLEN:0] : {r_rem[XLEN-1:0], r_acc[XLEN-1]};
    end

    // Sign fixup and result selection used in the FIX cycle.
    always_comb begin
        w_prod = r_neg ? -r_acc : r_acc;
        w_quot = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_remv = r_neg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
        case (r_op)
            3'd0:             w_result = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_result = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       w_result = w_quot;
            3'd6, 3'd7:       w_result = w_remv;
            default:          w_result = {XLEN{1'b0}};
        endcase
    end

    // State register and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= {CW{1'b0}};
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_count <= {CW{1'b0}};
            end else if (r_state == S_CALC) begin
                r_count <= r_count + CNT_ONE;
            end else begin
                r_count <= r_count;
            end
        end
    end

    // Datapath registers: loaded at accept, stepped in CALC, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= 3'd0;
            r_neg <= 1'b0;
            r_acc <= {(2*XLEN){1'b0}};
            r_rem <= {(XLEN+1){1'b0}};
            r_b   <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_op  <= bus.op;
            r_neg <= w_neg;
            r_rem <= {(XLEN+1){1'b0}};
            if (bus.op[2]) begin
                r_acc <= {{XLEN{1'b0}}, w_mag_a};
                r_b   <= w_mag_b;
            end else begin
                r_acc <= {{XLEN{1'b0}}, w_mag_b};
                r_b   <= w_mag_a;
            end
        end else if (r_state == S_CALC) begin
            if (r_op[2]) begin
                r_acc <= {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], w_div_ge};
                r_rem <= w_div_rem_next;
            end else begin
                r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
            end
        end else begin
            r_acc <= r_acc;
        end
    end

    // Result register: written only by an unkilled FIX cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= {XLEN{1'b0}};
        end else if ((r_state == S_FIX) && !bus.kill) begin
            r_out <= w_result;
        end else begin
            r_out <= r_out;
        end
    end

    assign bus.out  = r_out;
    assign bus.busy = (r_state == S_CALC) || (r_state == S_FIX);
    assign bus.done = (r_state == S_DONE);
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: randomized RV32M operations against an
// arithmetic reference model, plus handshake, kill, reset and XLEN=8 checks.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus32 ();
    muldiv_unit_if #(.XLEN(8))  bus8 ();

    muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    muldiv_unit #(.XLEN(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    typedef struct {
        logic [31:0] val;
        int          due;
        logic [2:0]  op;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] last_out = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        p  = 64'h0;
        case (op)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin r = sa * sb; p = r; return p[63:32]; end
            3'd2: begin r = sa * ub; p = r; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                r = sa / sb; p = r; return p[31:0];
            end
            3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                r = sa % sb; p = r; return p[31:0];
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest expected result and its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus32.done === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                e = sb_q.pop_front();
                if (bus32.out !== e.val) begin
                    n_fail++;
                    $display("FAIL result op=%0d: out=%h required %h", e.op, bus32.out, e.val);
                end
                n_checks++;
                if (cyc != e.due) begin
                    n_fail++;
                    $display("FAIL done_latency op=%0d: done at cycle %0d required %0d", e.op, cyc, e.due);
                end
                last_out = e.val;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] expv);
        int t;
        t = 0;
        while (bus32.busy !== 1'b0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (bus32.busy !== 1'b0) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: busy=%b after %0d cycles, required 0", bus32.busy, t);
        end
        bus32.start = 1'b1;
        bus32.op    = op;
        bus32.in_1  = a;
        bus32.in_2  = b;
        if (push) sb_q.push_back('{expv, cyc + 34, op});
        @(posedge clk); #1;
        bus32.start = 1'b0;
        bus32.op    = 3'($urandom);
        bus32.in_1  = $urandom;
        bus32.in_2  = $urandom;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_queue", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] expv);
        int c0, t;
        t = 0;
        while (bus8.busy !== 1'b0 && t < 50) begin @(posedge clk); #1; t++; end
        bus8.start = 1'b1; bus8.op = op; bus8.in_1 = a; bus8.in_2 = b;
        c0 = cyc;
        @(posedge clk); #1;
        bus8.start = 1'b0; bus8.in_1 = 8'($urandom); bus8.in_2 = 8'($urandom);
        t = 0;
        while (bus8.done !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        check("x8_result", {24'h0, bus8.out}, {24'h0, expv});
        check("x8_latency", 32'(cyc - c0), 32'd10);
    endtask

    logic [2:0]  d_op [13] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd4, 3'd6};
    logic [31:0] d_a  [13] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd100, 32'd100, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b  [13] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_e  [13] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};

    initial begin
        int          nb;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bus32.start = 1'b0; bus32.kill = 1'b0; bus32.op = 3'd0; bus32.in_1 = 32'h0; bus32.in_2 = 32'h0;
        bus8.start  = 1'b0; bus8.kill  = 1'b0; bus8.op  = 3'd0; bus8.in_1  = 8'h0;  bus8.in_2  = 8'h0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out", bus32.out, 32'h0);
        check("reset_busy", {31'h0, bus32.busy}, 32'h0);
        check("reset_done", {31'h0, bus32.done}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MUL with busy-length measurement, then a back-to-back start in the DONE cycle.
        issue(d_op[0], d_a[0], d_b[0], 1'b1, d_e[0]);
        nb = 0;
        while (bus32.busy === 1'b1 && nb < 100) begin nb++; @(posedge clk); #1; end
        check("busy_length", 32'(nb), 32'd33);
        check("done_after_busy", {31'h0, bus32.done}, 32'h1);
        for (int i = 1; i < 13; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1, d_e[i]);

        // A start presented in cycle 5 of an operation must be ignored.
        issue(3'd0, 32'd6, 32'd9, 1'b1, 32'd54);
        repeat (4) begin @(posedge clk); #1; end
        bus32.start = 1'b1; bus32.op = 3'd5; bus32.in_1 = 32'd1000; bus32.in_2 = 32'd3;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        drain();

        // Kill in cycle 10, with a simultaneous start that must be dropped.
        issue(3'd4, 32'd12345, 32'd7, 1'b0, 32'h0);
        repeat (9) begin @(posedge clk); #1; end
        bus32.kill = 1'b1; bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.kill = 1'b0; bus32.start = 1'b0;
        check("kill_busy", {31'h0, bus32.busy}, 32'h0);
        check("kill_out_hold", bus32.out, last_out);
        repeat (40) begin @(posedge clk); #1; end
        check("kill_out_after", bus32.out, last_out);

        for (int i = 0; i < 250; i++) begin
            rop = 3'($urandom);
            ra  = pick();
            rb  = pick();
            issue(rop, ra, rb, 1'b1, ref_model(rop, ra, rb));
        end
        drain();

        // Reset asserted mid-CALC discards the operation immediately.
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h0);
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("midreset_out", bus32.out, 32'h0);
        check("midreset_busy", {31'h0, bus32.busy}, 32'h0);
        check("midreset_done", {31'h0, bus32.done}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_out = 32'h0;
        repeat (40) begin @(posedge clk); #1; end
        check("post_reset_idle", {31'h0, bus32.busy}, 32'h0);
        check("post_reset_out", bus32.out, 32'h0);
        issue(3'd0, 32'd3, 32'd5, 1'b1, 32'd15);
        drain();

        run8(3'd0, 8'h0F, 8'h0F, 8'hE1);
        run8(3'd3, 8'hFF, 8'hFF, 8'hFE);
        run8(3'd4, 8'h80, 8'hFF, 8'h80);
        run8(3'd7, 8'd100, 8'd7, 8'd2);

        repeat (40) begin @(posedge clk); #1; end
        check("final_queue", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
